// File: rtl/demux4_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
package demux4_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int NUM_OUT       = 4;
  localparam int SEL_W         = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Round-robin successor; the 2-bit width makes 3 wrap to 0.
  function automatic sel_t next_rr(input sel_t ptr);
    return ptr + sel_t'(1);
  endfunction

endpackage

// File: rtl/demux4_reg_slot.sv
// One-entry holding slot: a fill loads data and sets valid, a taken word clears valid.
module demux4_reg_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             take,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && take) valid_d = 1'b0;
    // A refill in the same cycle as a drain wins, keeping the slot full with no bubble.
    if (fill) begin
      valid_d = 1'b1;
      data_d  = fill_data;
    end
  end

  // NOTE: the data register is reset too, because consumers see zero on every output after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all sequential state to avoid simulation races.
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer: steers one valid/ready stream to four independently stalling slots.
module demux4_reg
  import demux4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_en,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [WIDTH-1:0] out4_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr
);

  sel_t               rr_ptr_q, rr_ptr_d;
  sel_t               target;
  logic               accept;
  logic [NUM_OUT-1:0] fill;
  logic [NUM_OUT-1:0] slot_valid;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];

  always_comb begin
    target   = rr_en ? rr_ptr_q : in_sel;
    // Only the target slot gates the input: a full, stalled target blocks even if others are empty.
    in_ready = !slot_valid[target] || out_ready[target];
    accept   = in_valid && in_ready;
    fill     = '0;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      fill[target] = 1'b1;
      if (rr_en) rr_ptr_d = next_rr(rr_ptr_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux4_reg_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .fill      (fill[i]),
      .fill_data (in_data),
      .take      (out_ready[i]),
      .valid     (slot_valid[i]),
      .data      (slot_data[i])
    );
  end

  assign out_valid = slot_valid;
  assign out1_data = slot_data[0];
  assign out2_data = slot_data[1];
  assign out3_data = slot_data[2];
  assign out4_data = slot_data[3];
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Directed self-checking bench for demux4_reg with hand-computed expectations.
module tb_demux4_reg;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        rr_en;
  logic [31:0] out1_data, out2_data, out3_data, out4_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  demux4_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .out4_data (out4_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rr_words [5];
  logic [3:0]  rr_valid [5];
  logic [1:0]  rr_next  [5];

  initial begin
    rr_words = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    rr_valid = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_next  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    reset     = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    rr_en     = 1'b0;
    out_ready = 4'b0000;
    #1;
    check("reset_valid", {28'd0, out_valid}, 32'h0);
    check("reset_rr", {30'd0, rr_ptr}, 32'h0);
    check("reset_out1", out1_data, 32'h0);
    check("reset_out4", out4_data, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("reset_no_capture", {28'd0, out_valid}, 32'h0);
    reset = 1'b0;
    tick();
    check("idle_valid", {28'd0, out_valid}, 32'h0);
    check("idle_in_ready", {31'd0, in_ready}, 32'h1);

    // Explicit select, all consumers ready.
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA0001;
    in_sel    = 2'd2;
    #1;
    check("sel_in_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("sel_out3_data", out3_data, 32'hAAAA0001);
    check("sel_valid_0100", {28'd0, out_valid}, 32'h4);
    in_data = 32'hBBBB0002;
    in_sel  = 2'd0;
    tick();
    check("sel_out1_data", out1_data, 32'hBBBB0002);
    check("sel_valid_0001", {28'd0, out_valid}, 32'h1);
    in_valid = 1'b0;
    tick();
    check("sel_drained", {28'd0, out_valid}, 32'h0);
    check("sel_rr_unchanged", {30'd0, rr_ptr}, 32'h0);

    // Stall and head-of-line blocking on slot 2.
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    in_sel    = 2'd1;
    tick();
    check("stall_out2_first", out2_data, 32'h11);
    check("stall_valid_first", {28'd0, out_valid}, 32'h2);
    in_data = 32'h22;
    #1;
    check("hol_in_ready_low", {31'd0, in_ready}, 32'h0);
    tick();
    check("hol_out2_holds", out2_data, 32'h11);
    check("hol_no_other_fill", {28'd0, out_valid}, 32'h2);
    out_ready = 4'b0010;
    #1;
    check("hol_release_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("hol_out2_second", out2_data, 32'h22);
    check("hol_valid_kept", {28'd0, out_valid}, 32'h2);
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    tick();
    check("hol_drained", {28'd0, out_valid}, 32'h0);

    // Round robin with wrap.
    rr_en    = 1'b1;
    in_sel   = 2'd3;
    in_valid = 1'b1;
    check("rr_start", {30'd0, rr_ptr}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      in_data = rr_words[i];
      tick();
      check($sformatf("rr_valid_%0d", i), {28'd0, out_valid}, {28'd0, rr_valid[i]});
      check($sformatf("rr_ptr_%0d", i), {30'd0, rr_ptr}, {30'd0, rr_next[i]});
    end
    check("rr_out1_wrap", out1_data, 32'h50);
    check("rr_out2", out2_data, 32'h20);
    check("rr_out3", out3_data, 32'h30);
    check("rr_out4", out4_data, 32'h40);
    in_valid = 1'b0;
    tick();
    check("rr_idle_hold", {30'd0, rr_ptr}, 32'h1);
    check("rr_idle_valid", {28'd0, out_valid}, 32'h0);

    // Simultaneous drain and fill of slot 1.
    rr_en     = 1'b0;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 32'h5;
    tick();
    check("df_first", out1_data, 32'h5);
    out_ready = 4'b0001;
    in_data   = 32'h6;
    #1;
    check("df_in_ready", {31'd0, in_ready}, 32'h1);
    tick();
    check("df_valid_kept", {28'd0, out_valid}, 32'h1);
    check("df_second", out1_data, 32'h6);
    check("df_rr_hold", {30'd0, rr_ptr}, 32'h1);
    in_valid = 1'b0;
    tick();
    check("df_drained", {28'd0, out_valid}, 32'h0);

    // Reset mid-operation with two full slots and rr_ptr at 3.
    rr_en     = 1'b1;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_data   = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    in_valid = 1'b0;
    check("mid_setup_valid", {28'd0, out_valid}, 32'h6);
    check("mid_setup_rr", {30'd0, rr_ptr}, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_valid", {28'd0, out_valid}, 32'h0);
    check("mid_reset_rr", {30'd0, rr_ptr}, 32'h0);
    check("mid_reset_out2", out2_data, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_valid", {28'd0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
